// File: rtl/mfe_led7seg_pkg.sv
// Shared definitions for the led7seg family of blocks.
//  - seg_bit_t   : bit positions of each segment inside an 8-bit pattern {dp,g,f,e,d,c,b,a}
//  - SEG_BLANK   : all-segments-off pattern (active-high form)
//  - hex_to_seg  : hex nibble -> active-high segment pattern (dp cleared)
//  - scan/shift FSM state types used by the 74HC595 scan driver
package mfe_led7seg_pkg;

  typedef enum int {
    SEG_A  = 0,
    SEG_B  = 1,
    SEG_C  = 2,
    SEG_D  = 3,
    SEG_E  = 4,
    SEG_F  = 5,
    SEG_G  = 6,
    SEG_DP = 7
  } seg_bit_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {
    SCAN_LOAD,
    SCAN_SHIFT,
    SCAN_DWELL
  } scan_state_t;

  typedef enum logic [1:0] {
    SH_IDLE,
    SH_SHIFT,
    SH_LATCH
  } sh_state_t;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      default: seg = 8'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/mfe_hc595_shifter.sv
// Serialises one W-bit frame into a chain of 74HC595 registers, MSB first,
// then pulses the storage clock once.
// Ports:
//  clk, rst     clock, synchronous active-high reset
//  load         start a frame (accepted only while idle)
//  frame        W-bit frame captured on load
//  busy         high while shifting/latching; drops in the final latch cycle
//  sclk         shift clock: CLK_DIV cycles low, CLK_DIV cycles high per bit
//  rclk         storage clock: high CLK_DIV cycles after the last bit
//  dio          serial data, updated at the start of each sclk-low phase
module mfe_hc595_shifter
  import mfe_led7seg_pkg::*;
#(
  parameter int W       = 16,
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] frame,
  output logic         busy,
  output logic         sclk,
  output logic         rclk,
  output logic         dio
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  sh_state_t      r_state, w_state_nxt;
  logic [W-1:0]   r_sh,    w_sh_nxt;
  logic [CW-1:0]  r_cnt,   w_cnt_nxt;
  logic [BW-1:0]  r_bit,   w_bit_nxt;
  logic           r_high,  w_high_nxt;
  logic           r_sclk,  w_sclk_nxt;
  logic           r_rclk,  w_rclk_nxt;
  logic           r_dio,   w_dio_nxt;
  logic           w_cnt_last;

  assign w_cnt_last = (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SH_IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_high  <= 1'b0;
      r_sclk  <= 1'b0;
      r_rclk  <= 1'b0;
      r_dio   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_high  <= w_high_nxt;
      r_sclk  <= w_sclk_nxt;
      r_rclk  <= w_rclk_nxt;
      r_dio   <= w_dio_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_high_nxt  = r_high;
    w_sclk_nxt  = r_sclk;
    w_rclk_nxt  = r_rclk;
    w_dio_nxt   = r_dio;
    case (r_state)
      SH_IDLE: begin
        if (load) begin
          // First bit goes out with the load; r_sh holds the remaining bits at its MSB.
          w_state_nxt = SH_SHIFT;
          w_dio_nxt   = frame[W-1];
          w_sh_nxt    = frame << 1;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_high_nxt  = 1'b0;
          w_sclk_nxt  = 1'b0;
        end
      end
      SH_SHIFT: begin
        if (w_cnt_last) begin
          w_cnt_nxt = '0;
          if (!r_high) begin
            w_sclk_nxt = 1'b1;
            w_high_nxt = 1'b1;
          end else if (r_bit == BW'(W - 1)) begin
            w_sclk_nxt  = 1'b0;
            w_high_nxt  = 1'b0;
            w_rclk_nxt  = 1'b1;
            w_state_nxt = SH_LATCH;
          end else begin
            w_sclk_nxt = 1'b0;
            w_high_nxt = 1'b0;
            w_dio_nxt  = r_sh[W-1];
            w_sh_nxt   = r_sh << 1;
            w_bit_nxt  = r_bit + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      SH_LATCH: begin
        if (w_cnt_last) begin
          w_cnt_nxt   = '0;
          w_rclk_nxt  = 1'b0;
          w_state_nxt = SH_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = SH_IDLE;
    endcase
  end

  // busy drops one cycle early so the caller's next state lines up with the idle cycle.
  assign busy = (r_state != SH_IDLE) && !((r_state == SH_LATCH) && w_cnt_last);
  assign sclk = r_sclk;
  assign rclk = r_rclk;
  assign dio  = r_dio;

endmodule

// File: rtl/mfe_led7seg_74hc595_scan.sv
// Self-scanning driver for an N-digit 7-segment board built from chained 74HC595s.
// Holds a per-digit pattern buffer, decodes hex or stores raw patterns, and sends
// one {seg[7:0], sel[NUM_DIGITS-1:0]} frame per digit followed by a dwell time.
// Ports:
//  clk, rst    clock, synchronous active-high reset
//  wr_en       buffer write strobe (any cycle, any state)
//  wr_addr     digit index; indexes >= NUM_DIGITS are ignored
//  wr_raw      1: wr_data is a raw {dp,g,f,e,d,c,b,a} pattern; 0: hex nibble + dp in bit 7
//  wr_data     write data
//  dig_en      per-digit enable, sampled when a digit's frame is loaded
//  sclk, rclk, dio  74HC595 shift clock, storage clock, serial data
//  frame_done  1-cycle pulse after the last digit's dwell
module mfe_led7seg_74hc595_scan
  import mfe_led7seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 4,
  parameter int HOLD_CYCLES    = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 0,
  localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic                  wr_raw,
  input  logic [7:0]            wr_data,
  input  logic [NUM_DIGITS-1:0] dig_en,
  output logic                  sclk,
  output logic                  rclk,
  output logic                  dio,
  output logic                  frame_done
);

  localparam int            SW        = 8 + NUM_DIGITS;
  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int            HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam logic [AW-1:0] IDX_LAST  = AW'(NUM_DIGITS - 1);

  logic [7:0]            r_buf [NUM_DIGITS];
  scan_state_t           r_state, w_state_nxt;
  logic [AW-1:0]         r_idx, w_idx_nxt;
  logic [HW-1:0]         r_hold, w_hold_nxt;
  logic                  r_frame_done, w_frame_done_nxt;
  logic                  w_load, w_busy, w_advance;
  logic [7:0]            w_wr_pat, w_seg;
  logic [NUM_DIGITS-1:0] w_sel;
  logic [SW-1:0]         w_frame;

  always_comb begin
    w_wr_pat = wr_raw ? wr_data : hex_to_seg(wr_data[3:0]);
    if (!wr_raw) w_wr_pat[SEG_DP] = wr_data[7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) r_buf[i] <= SEG_BLANK;
    end else if (wr_en && (32'(wr_addr) < NUM_DIGITS)) begin
      r_buf[wr_addr] <= w_wr_pat;
    end
  end

  // Frame is built from registered buffer contents and captured by the shifter on load,
  // so a write landing on the load edge only shows up on the next scan.
  always_comb begin
    w_seg = dig_en[r_idx] ? r_buf[r_idx] : SEG_BLANK;
    if (SEG_ACTIVE_LOW != 0) w_seg = ~w_seg;
    w_sel = (NUM_DIGITS)'(1) << r_idx;
    if (DIG_ACTIVE_LOW != 0) w_sel = ~w_sel;
    w_frame = {w_seg, w_sel};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SCAN_LOAD;
      r_idx        <= '0;
      r_hold       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_hold       <= w_hold_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_hold_nxt       = r_hold;
    w_frame_done_nxt = 1'b0;
    w_load           = 1'b0;
    w_advance        = 1'b0;
    case (r_state)
      SCAN_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = SCAN_SHIFT;
      end
      SCAN_SHIFT: begin
        if (!w_busy) begin
          if (HOLD_CYCLES == 0) begin
            w_advance = 1'b1;
          end else begin
            w_hold_nxt  = '0;
            w_state_nxt = SCAN_DWELL;
          end
        end
      end
      SCAN_DWELL: begin
        if (r_hold == HW'(HOLD_LAST)) w_advance = 1'b1;
        else                          w_hold_nxt = r_hold + 1'b1;
      end
      default: w_state_nxt = SCAN_LOAD;
    endcase
    if (w_advance) begin
      w_state_nxt = SCAN_LOAD;
      if (r_idx == IDX_LAST) begin
        w_idx_nxt        = '0;
        w_frame_done_nxt = 1'b1;
      end else begin
        w_idx_nxt = r_idx + 1'b1;
      end
    end
  end

  mfe_hc595_shifter #(
    .W       (SW),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .frame (w_frame),
    .busy  (w_busy),
    .sclk  (sclk),
    .rclk  (rclk),
    .dio   (dio)
  );

  assign frame_done = r_frame_done;

endmodule
